// File: rtl/pwm_carrier_pkg.sv
// Shared types for the PWM carrier block: carrier modes, FSM states and the
// on/off control encoding.
package pwm_carrier_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    CAR_UP     = 2'd0,
    CAR_DOWN   = 2'd1,
    CAR_UPDOWN = 2'd2
  } _car_mode;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } _car_state;

  typedef enum logic [1:0] {
    PWM_OFF = 2'd0,
    PWM_ON  = 2'd1
  } _pwm_onoff;

  // Direction a mode starts in; the unused 4th mode encoding behaves as up/down.
  function automatic logic start_dir(input _car_mode mode, input logic init_dir);
    case (mode)
      CAR_UP:   return 1'b1;
      CAR_DOWN: return 1'b0;
      default:  return init_dir;
    endcase
  endfunction

endpackage

// File: rtl/pwm_period_shadow.sv
// Shadow copy of the software period register. The new value is exposed
// combinationally so the carrier can restart from it on the load edge.
module pwm_period_shadow
  import pwm_carrier_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] period_sh,
  output logic [CNT_WIDTH-1:0] period_sh_next
);

  assign period_sh_next = load ? period : period_sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) period_sh <= '0;
    else        period_sh <= period_sh_next;
  end

endmodule

// File: rtl/pwm_carrier.sv
// Carrier counter (up / down / up-down) with shadowed period, phase sync and
// zero/period event pulses decoded from the next-state count.
//
// state | meaning
// IDLE  | carrier parked at clamped init value, shadow tracks period
// RUN   | carrier stepping, shadow reloads only at boundary
module pwm_carrier
  import pwm_carrier_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  _pwm_onoff            pwm_onoff,
  input  _car_mode             car_mode,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] init_val,
  input  logic                 init_dir,
  input  logic                 sync_in,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 evt_zero,
  output logic                 evt_period,
  output logic                 running
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  _car_state            state;
  _car_state            state_next;
  logic                 run_req;
  logic                 step_en;
  logic                 idle_load;
  logic                 boundary;
  logic                 shadow_load;
  logic [CNT_WIDTH-1:0] period_sh;
  logic [CNT_WIDTH-1:0] period_sh_next;
  logic [CNT_WIDTH-1:0] init_clamp;
  logic                 dir_init;
  logic [CNT_WIDTH-1:0] count_n;
  logic                 dir_n;

  assign run_req = (pwm_onoff != PWM_OFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run_req)  state_next = RUN;
      RUN:     if (!run_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    step_en   = 1'b0;
    idle_load = 1'b0;
    case (state)
      IDLE:    idle_load = 1'b1;
      RUN:     step_en   = run_req;
      default: idle_load = 1'b1;
    endcase
  end

  // Boundary uses only current values so the shadow load has no loop through count_n.
  always_comb begin
    boundary = 1'b0;
    if (step_en && !sync_in) begin
      case (car_mode)
        CAR_UP:   boundary = (count >= period_sh);
        CAR_DOWN: boundary = (count == '0);
        default:  boundary = (count == '0);
      endcase
    end
  end

  assign shadow_load = idle_load || boundary;

  pwm_period_shadow #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_period_shadow (
    .clk            (clk),
    .reset          (reset),
    .load           (shadow_load),
    .period         (period),
    .period_sh      (period_sh),
    .period_sh_next (period_sh_next)
  );

  assign init_clamp = (init_val < period_sh_next) ? init_val : period_sh_next;
  assign dir_init   = start_dir(car_mode, init_dir);

  always_comb begin
    count_n = init_clamp;
    dir_n   = dir_init;
    if (step_en && !sync_in) begin
      case (car_mode)
        CAR_UP: begin
          count_n = (count >= period_sh) ? '0 : count + ONE;
          dir_n   = 1'b1;
        end
        CAR_DOWN: begin
          dir_n = 1'b0;
          if (count == '0)           count_n = period_sh_next;
          else if (count > period_sh) count_n = period_sh;
          else                       count_n = count - ONE;
        end
        default: begin
          // Direction flips on the cycle the extreme is shown, so each extreme lasts one cycle.
          if (count == '0) begin
            if (period_sh_next == '0) begin
              count_n = '0;
              dir_n   = 1'b1;
            end else begin
              count_n = ONE;
              dir_n   = (period_sh_next != ONE);
            end
          end else if (count > period_sh) begin
            count_n = period_sh;
            dir_n   = (period_sh == '0);
          end else if (count == period_sh) begin
            count_n = count - ONE;
            dir_n   = (count_n == '0);
          end else if (dir) begin
            count_n = count + ONE;
            dir_n   = (count_n != period_sh);
          end else begin
            count_n = count - ONE;
            dir_n   = (count_n == '0);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      dir        <= 1'b1;
      evt_zero   <= 1'b0;
      evt_period <= 1'b0;
      running    <= 1'b0;
    end else begin
      count      <= count_n;
      dir        <= dir_n;
      evt_zero   <= (state_next == RUN) && (count_n == '0);
      evt_period <= (state_next == RUN) && (count_n == period_sh_next);
      running    <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_pwm_carrier.sv
// Scoreboard bench for pwm_carrier: stimulus queues the expected outputs for
// the next edge, a negedge monitor pops and compares them.
module tb_pwm_carrier;
  import pwm_carrier_pkg::*;

  logic        clk;
  logic        reset;
  _pwm_onoff   pwm_onoff;
  _car_mode    car_mode;
  logic [15:0] period;
  logic [15:0] init_val;
  logic        init_dir;
  logic        sync_in;
  logic [15:0] count;
  logic        dir;
  logic        evt_zero;
  logic        evt_period;
  logic        running;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] count;
    logic        dir;
    logic        ez;
    logic        ep;
    logic        run;
  } exp_t;

  exp_t exp_q[$];

  pwm_carrier #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_onoff  (pwm_onoff),
    .car_mode   (car_mode),
    .period     (period),
    .init_val   (init_val),
    .init_dir   (init_dir),
    .sync_in    (sync_in),
    .count      (count),
    .dir        (dir),
    .evt_zero   (evt_zero),
    .evt_period (evt_period),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the entry scheduled for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if ({count, dir, evt_zero, evt_period, running} !== {e.count, e.dir, e.ez, e.ep, e.run}) begin
          failures++;
          $display("FAIL %s: got count=%0d dir=%b ez=%b ep=%b run=%b, want count=%0d dir=%b ez=%b ep=%b run=%b",
                   e.name, count, dir, evt_zero, evt_period, running,
                   e.count, e.dir, e.ez, e.ep, e.run);
        end
      end else if (exp_q[0].cyc < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end
    end
  end

  // Queue what the outputs must be after the next edge, then advance past it.
  task automatic exp_next(input string name, input int c, input bit d,
                          input bit ez, input bit ep, input bit run);
    exp_t e;
    e.cyc   = cyc + 1;
    e.name  = name;
    e.count = 16'(c);
    e.dir   = d;
    e.ez    = ez;
    e.ep    = ep;
    e.run   = run;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [19:0] act, input logic [19:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got {count,dir,ez,ep,run}=%h, want %h", name, act, want);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    pwm_onoff = PWM_OFF;
    car_mode  = CAR_UP;
    period    = 16'd4;
    init_val  = 16'd0;
    init_dir  = 1'b1;
    sync_in   = 1'b0;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    #1;
    check_now("reset_values", {count, dir, evt_zero, evt_period, running}, {16'd0, 4'b1000});
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // UP, P=4
    exp_next("up_idle", 0, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("up_c0", 0, 1, 1, 0, 1);
    exp_next("up_c1", 1, 1, 0, 0, 1);
    exp_next("up_c2", 2, 1, 0, 0, 1);
    exp_next("up_c3", 3, 1, 0, 0, 1);
    exp_next("up_c4", 4, 1, 0, 1, 1);
    exp_next("up_wrap", 0, 1, 1, 0, 1);
    exp_next("up_c1b", 1, 1, 0, 0, 1);
    pwm_onoff = PWM_OFF;
    exp_next("up_off", 0, 1, 0, 0, 0);

    // UPDOWN, P=3
    car_mode = CAR_UPDOWN;
    period   = 16'd3;
    exp_next("ud_idle", 0, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("ud_0", 0, 1, 1, 0, 1);
    exp_next("ud_1", 1, 1, 0, 0, 1);
    exp_next("ud_2", 2, 1, 0, 0, 1);
    exp_next("ud_3top", 3, 0, 0, 1, 1);
    exp_next("ud_2dn", 2, 0, 0, 0, 1);
    exp_next("ud_1dn", 1, 0, 0, 0, 1);
    exp_next("ud_0bot", 0, 1, 1, 0, 1);
    exp_next("ud_1up", 1, 1, 0, 0, 1);
    exp_next("ud_2up", 2, 1, 0, 0, 1);
    exp_next("ud_3top2", 3, 0, 0, 1, 1);
    pwm_onoff = PWM_OFF;
    exp_next("ud_off", 0, 1, 0, 0, 0);

    // UP, P=6, shadow write mid-ramp
    car_mode = CAR_UP;
    period   = 16'd6;
    exp_next("sh_idle", 0, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("sh_0", 0, 1, 1, 0, 1);
    exp_next("sh_1", 1, 1, 0, 0, 1);
    exp_next("sh_2", 2, 1, 0, 0, 1);
    exp_next("sh_3", 3, 1, 0, 0, 1);
    period = 16'd2;
    exp_next("sh_4", 4, 1, 0, 0, 1);
    exp_next("sh_5", 5, 1, 0, 0, 1);
    exp_next("sh_6", 6, 1, 0, 1, 1);
    exp_next("sh_wrap", 0, 1, 1, 0, 1);
    exp_next("sh_new1", 1, 1, 0, 0, 1);
    exp_next("sh_new2", 2, 1, 0, 1, 1);
    exp_next("sh_new_wrap", 0, 1, 1, 0, 1);
    pwm_onoff = PWM_OFF;
    exp_next("sh_off", 0, 1, 0, 0, 0);

    // DOWN, P=5, clamped init, sync
    car_mode = CAR_DOWN;
    period   = 16'd5;
    init_val = 16'd9;
    exp_next("dn_idle_clamp", 5, 0, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("dn_5", 5, 0, 0, 1, 1);
    exp_next("dn_4", 4, 0, 0, 0, 1);
    exp_next("dn_3", 3, 0, 0, 0, 1);
    exp_next("dn_2", 2, 0, 0, 0, 1);
    exp_next("dn_1", 1, 0, 0, 0, 1);
    exp_next("dn_0", 0, 0, 1, 0, 1);
    exp_next("dn_reload", 5, 0, 0, 1, 1);
    exp_next("dn_4b", 4, 0, 0, 0, 1);
    exp_next("dn_3b", 3, 0, 0, 0, 1);
    sync_in  = 1'b1;
    init_val = 16'd2;
    exp_next("dn_sync", 2, 0, 0, 0, 1);
    sync_in = 1'b0;
    exp_next("dn_after_sync1", 1, 0, 0, 0, 1);
    exp_next("dn_after_sync0", 0, 0, 1, 0, 1);
    pwm_onoff = PWM_OFF;
    exp_next("dn_off", 2, 0, 0, 0, 0);

    // P=0 in every mode
    car_mode = CAR_UP;
    period   = 16'd0;
    init_val = 16'd0;
    exp_next("p0_idle", 0, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("p0_up_a", 0, 1, 1, 1, 1);
    exp_next("p0_up_b", 0, 1, 1, 1, 1);
    exp_next("p0_up_c", 0, 1, 1, 1, 1);
    car_mode = CAR_DOWN;
    exp_next("p0_dn_a", 0, 0, 1, 1, 1);
    exp_next("p0_dn_b", 0, 0, 1, 1, 1);
    car_mode = CAR_UPDOWN;
    exp_next("p0_ud_a", 0, 1, 1, 1, 1);
    exp_next("p0_ud_b", 0, 1, 1, 1, 1);
    car_mode = _car_mode'(2'd3);
    exp_next("p0_mode3", 0, 1, 1, 1, 1);
    pwm_onoff = PWM_OFF;
    exp_next("p0_off", 0, 1, 0, 0, 0);

    // Off mid-ramp, then async reset mid-run
    car_mode = CAR_UP;
    period   = 16'd6;
    init_val = 16'd5;
    exp_next("rs_idle", 5, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("rs_5", 5, 1, 0, 0, 1);
    exp_next("rs_6", 6, 1, 0, 1, 1);
    exp_next("rs_0", 0, 1, 1, 0, 1);
    exp_next("rs_1", 1, 1, 0, 0, 1);
    exp_next("rs_2", 2, 1, 0, 0, 1);
    exp_next("rs_3", 3, 1, 0, 0, 1);
    pwm_onoff = PWM_OFF;
    exp_next("rs_off_at3", 5, 1, 0, 0, 0);
    pwm_onoff = PWM_ON;
    exp_next("rs_rerun5", 5, 1, 0, 0, 1);
    exp_next("rs_rerun6", 6, 1, 0, 1, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_now("async_reset", {count, dir, evt_zero, evt_period, running}, {16'd0, 4'b1000});
    pwm_onoff = PWM_OFF;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_next("rs_post_idle", 5, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_carrier.md
# pwm_carrier

16-bit PWM carrier generator clocked by the PWM clock chosen by the clock selector. It produces the triangular or sawtooth carrier count that the PWM comparators and dead-time stage consume. It also produces the zero and period event pulses used by the event triggers. The period register is shadowed, so software writes take effect only on a carrier boundary and never mid-ramp.

## Interface
- CNT_WIDTH, 16, carrier counter and period width
- clk  in  1  PWM clock (selected-clock output); only clock of the block
- reset  in  1  asynchronous, active-low (0 = reset)
- pwm_onoff  in  _pwm_onoff  PWM_OFF holds block idle; any other value runs
- car_mode  in  _car_mode  CAR_UP, CAR_DOWN, CAR_UPDOWN; the 4th encoding behaves as CAR_UPDOWN
- period  in  CNT_WIDTH  carrier period P (software register, shadowed)
- init_val  in  CNT_WIDTH  start/phase count
- init_dir  in  1  start direction in CAR_UPDOWN (1 = up)
- sync_in  in  1  phase resync request, sampled each cycle
- count  out  CNT_WIDTH  carrier value
- dir  out  1  current direction (1 = up)
- evt_zero  out  1  high in every cycle where count == 0 while running
- evt_period  out  1  high in every cycle where count == period_sh while running
- running  out  1  state == RUN

## Operation
- States: IDLE and RUN.
- IDLE → RUN when pwm_onoff != PWM_OFF.
- RUN → IDLE on the first cycle pwm_onoff == PWM_OFF.
- period_sh (internal shadow) behaviour:
  - In IDLE, loads period every cycle.
  - In RUN, loads only at the boundary cycle: the step from which count restarts (defined per mode below).
- Clamped init is L = min(init_val, period_sh_next), where period_sh_next is the shadow value in force after the current edge.
- IDLE behaviour:
  - count <= L; dir <= init_dir in CAR_UPDOWN, 1 in CAR_UP, 0 in CAR_DOWN.
  - Events low; running low.
- RUN stepping, per mode:
  - CAR_UP: 0,1,…,P,0,…; boundary is the step P→0; carrier period P+1 cycles; dir = 1.
  - CAR_DOWN: P,…,1,0,P,…; boundary is the step 0→P, and the restart value is the new period_sh; dir = 0.
  - CAR_UPDOWN: counts up to P, dir flips to 0, counts down to 0, dir flips to 1.
    - Boundary is the step leaving 0 upward.
    - Each extreme appears for exactly one cycle; carrier period 2P cycles.
- sync_in = 1 in RUN:
  - Next count = L and next dir = init_dir (CAR_UPDOWN only).
  - No shadow load.
  - sync_in overrides wrap or turn-around in the same cycle.
- car_mode change in RUN takes effect on the next step from the current count.
  - If count > period_sh, CAR_UP wraps to 0 next cycle.
  - If count > period_sh, CAR_DOWN and CAR_UPDOWN load period_sh next cycle.
- P = 0: count stays 0 and evt_zero = evt_period = 1 every RUN cycle. In CAR_UPDOWN, dir stays 1.
- Arithmetic is unsigned CNT_WIDTH; no overflow is possible since count ≤ period_sh.

## Timing
- All outputs are registered. Events are decoded from next-state values, so each event is aligned with the count value it describes.
- Reset values: state IDLE, count 0, dir 1, evt_zero 0, evt_period 0, running 0, period_sh 0.
- The first RUN cycle shows count = L. The first increment or decrement appears on the following cycle.
- pwm_onoff → PWM_OFF mid-ramp: on the next edge count = L, events 0, running 0; no boundary is needed.
- Reset assertion mid-run clears all outputs immediately (asynchronously). Release is synchronised by the instantiating level.
- Latency:
  - sync_in → count = L: 1 cycle.
  - period write → used: next boundary, or 1 cycle if IDLE.

## Structure
- In PKG_pwm:
  - typedef _car_mode (2 bits: CAR_UP = 0, CAR_DOWN = 1, CAR_UPDOWN = 2).
  - typedef _car_state (IDLE, RUN).
  - The existing _pwm_onoff/PWM_OFF.
- One natural sub-module: pwm_period_shadow, which holds the shadow register with load-enable (IDLE || boundary).
- The stepping logic and state machine stay in pwm_carrier.

## Test plan
- CAR_UP, P = 4, init_val = 0, enable → count 0,1,2,3,4,0,1; evt_zero at each 0; evt_period at each 4; running rises 1 cycle after enable.
- CAR_UPDOWN, P = 3, init_dir = 1 → count 0,1,2,3,2,1,0,1; dir 1,1,1,0,0,0,1,1 (dir flips on the cycle count shows the extreme); evt_period once per 6-cycle period.
- CAR_UP, P = 6, write period = 2 while count = 3 → ramp continues 4,5,6,0,1,2,0; evt_period at 6 then at 2.
- CAR_DOWN, P = 5, init_val = 9 → first RUN count = 5 (clamped), then 4,…,0,5; sync_in with init_val = 2 at count 3 → next count 2.
- pwm_onoff → PWM_OFF at count 3, then reset pulsed low mid-ramp → count = L next edge with events 0; reset forces count 0, dir 1, running 0 without a clock edge.
- P = 0 in every mode → count stays 0; evt_zero and evt_period both high every RUN cycle.
